// File: rtl/nios2_proc_hall_in_if.sv
// nios2_proc_hall_in_if
//   Avalon-MM slave bus bundle for the hall-sensor input port.
//   Signals:
//     address     2   register select
//     chipselect  1   slave select
//     write_n     1   active-low write strobe
//     writedata   32  write data
//     readdata    32  read data, combinational, zero wait states
//   Modports:
//     master  drives address/chipselect/write_n/writedata, samples readdata
//     slave   samples the request signals, drives readdata
interface nios2_proc_hall_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_proc_hall_in.sv
// nios2_proc_hall_in
//   Avalon-MM input port for BLDC hall sensors. Raw lines are synchronised,
//   debounced and edge-detected. Edges are latched into a W1C capture register
//   that drives a maskable level interrupt. The number of cycles between
//   successive debounced transitions is published as the commutation period.
//   Ports:
//     clk      in   1      system clock
//     reset_n  in   1      asynchronous active-low reset
//     bus      slave       Avalon-MM register interface (see nios2_proc_hall_in_if)
//     in_port  in   WIDTH  raw asynchronous hall inputs
//     irq      out  1      interrupt request, active high, level
//   Register map:
//     0 DATA     RO    debounced value
//     1 IRQMASK  RW    interrupt mask
//     2 PERIOD   RO    cycles between the last two debounced transitions
//     3 EDGECAP  RW1C  captured edges
module nios2_proc_hall_in #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios2_proc_hall_in_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam logic [1:0]  ADDR_DATA    = 2'd0;
  localparam logic [1:0]  ADDR_IRQMASK = 2'd1;
  localparam logic [1:0]  ADDR_PERIOD  = 2'd2;
  localparam logic [1:0]  ADDR_EDGECAP = 2'd3;
  localparam logic [15:0] CNT_LAST     = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [15:0]      cnt [WIDTH];
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] clear_bits;
  logic             any_transition;
  logic             wr_en;
  logic [31:0]      pcnt;
  logic [31:0]      period_reg;
  logic             unused_writedata;

  // Only the low WIDTH bits of writedata are meaningful.
  assign unused_writedata = ^bus.writedata;

  assign wr_en = bus.chipselect && !bus.write_n;

  // Two-flop synchroniser; the first stage may go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

  // Per-bit debounce: the counter tracks how long sync has disagreed with
  // deb. Any agreeing sample restarts the count, so only a run of
  // DEBOUNCE_CYCLES consecutive differing samples moves deb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Delayed copy of deb for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  // Edge qualification selected by EDGE_TYPE; the period counter always
  // uses any transition regardless of the capture mode.
  always_comb begin
    edge_sel = deb_d ^ deb;
    if (EDGE_TYPE == 0) begin
      edge_sel = ~deb_d & deb;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = deb_d & ~deb;
    end
  end

  assign any_transition = |(deb_d ^ deb);

  assign clear_bits = (wr_en && bus.address == ADDR_EDGECAP) ?
                      bus.writedata[WIDTH-1:0] : '0;

  // Edge capture: the set term is OR-ed in after the clear so that an edge
  // arriving on the same cycle as a W1C write is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap <= '0;
    end else begin
      cap <= (cap & ~clear_bits) | edge_sel;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (wr_en && bus.address == ADDR_IRQMASK) begin
      mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Commutation period: pcnt restarts at 1 on the cycle a transition is
  // seen, so two transitions N cycles apart publish exactly N. The counter
  // sticks at all-ones so a stalled motor reads as saturated, not wrapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt       <= '0;
      period_reg <= '0;
    end else if (any_transition) begin
      period_reg <= pcnt;
      pcnt       <= 32'd1;
    end else if (pcnt != 32'hFFFF_FFFF) begin
      pcnt <= pcnt + 32'd1;
    end
  end

  assign irq = |(cap & mask);

  // Zero-wait-state read mux; unused upper bits read as zero.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata[WIDTH-1:0] = deb;
      ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = mask;
      ADDR_PERIOD:  bus.readdata = period_reg;
      ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = cap;
      default:      bus.readdata = '0;
    endcase
  end

endmodule
